// File: rtl/pio_bus_pkg.sv
// rtl/pio_bus_pkg.sv - shared types, widths and read-modify-write helper for the PIO register bus
package pio_bus_pkg;

    localparam int PIO_ADDR_W = 10;
    localparam int PIO_DATA_W = 32;

    typedef enum logic [2:0] {
        OP_WRITE = 3'd0,
        OP_READ  = 3'd1,
        OP_SET   = 3'd2,
        OP_CLR   = 3'd3,
        OP_XOR   = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } state_e;

    // New register value for a transaction; plain WRITE passes the data through.
    function automatic logic [PIO_DATA_W-1:0] rmw_data(
        input op_e                   op,
        input logic [PIO_DATA_W-1:0] old_val,
        input logic [PIO_DATA_W-1:0] mask
    );
        case (op)
            OP_SET:  rmw_data = old_val | mask;
            OP_CLR:  rmw_data = old_val & ~mask;
            OP_XOR:  rmw_data = old_val ^ mask;
            default: rmw_data = mask;
        endcase
    endfunction

endpackage

// File: rtl/pio_reg_master.sv
// rtl/pio_reg_master.sv - single-outstanding bus initiator for the PIO control register file
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready              request handshake; req_op, req_addr, req_data payload
//   rsp_valid/rsp_ready              response handshake; rsp_data, rsp_err payload
//   bus_write_addr/en, bus_wdata     register file write port
//   bus_read_addr, bus_rdata         register file read port
module pio_reg_master
    import pio_bus_pkg::*;
#(
    parameter int ADDR_W = PIO_ADDR_W,
    parameter int DATA_W = PIO_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] bus_write_addr,
    output logic              bus_write_en,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [ADDR_W-1:0] bus_read_addr,
    input  logic [DATA_W-1:0] bus_rdata
);

    state_e            state, state_nxt;
    op_e               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [2:0]        cnt;
    logic              req_legal;

    assign req_legal = (req_op <= 3'd4) && (req_addr[1:0] == 2'b00);

    always_comb begin
        state_nxt    = state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        bus_write_en = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!req_legal)                 state_nxt = ST_RESP;
                    else if (req_op == 3'(OP_WRITE)) state_nxt = ST_WR;
                    else                            state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                if (cnt == 3'd0) state_nxt = (op_q == OP_READ) ? ST_RESP : ST_WR;
            end
            ST_WR: begin
                bus_write_en = 1'b1;
                state_nxt    = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus address/data are loaded on entry to WR/RD so they are valid for the
    // whole bus cycle, then left alone so they hold between transactions.
    // rsp_data doubles as the old-value register for read-modify-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            op_q           <= OP_WRITE;
            addr_q         <= '0;
            data_q         <= '0;
            cnt            <= '0;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
            bus_write_addr <= '0;
            bus_wdata      <= '0;
            bus_read_addr  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q   <= op_e'(req_op);
                        addr_q <= req_addr;
                        data_q <= req_data;
                        if (!req_legal) begin
                            rsp_err  <= 1'b1;
                            rsp_data <= '0;
                        end else if (req_op == 3'(OP_WRITE)) begin
                            rsp_err        <= 1'b0;
                            rsp_data       <= '0;
                            bus_write_addr <= req_addr;
                            bus_wdata      <= req_data;
                        end else begin
                            bus_read_addr <= req_addr;
                            cnt           <= 3'(RD_LAT - 1);
                        end
                    end
                end
                ST_RD: begin
                    if (cnt == 3'd0) begin
                        rsp_err  <= 1'b0;
                        rsp_data <= bus_rdata;
                        if (op_q != OP_READ) begin
                            bus_write_addr <= addr_q;
                            bus_wdata      <= rmw_data(op_q, bus_rdata, data_q);
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_reg_master.sv
// tb/tb_pio_reg_master.sv - directed self-checking bench for pio_reg_master
module tb_pio_reg_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [2:0]  req_op = 3'd0;
    logic [9:0]  req_addr = '0, waddr, raddr;
    logic [31:0] req_data = '0, rsp_data, wdata, rdata;
    logic        wen;

    logic        req_valid3 = 1'b0, req_ready3, rsp_valid3, rsp_err3, wen3;
    logic [9:0]  waddr3, raddr3;
    logic [31:0] rsp_data3, wdata3, rdata3, rd3_p1, rd3_p2;

    logic [31:0] mem [256];
    int          wr_cnt = 0, wr_cnt3 = 0;
    logic [9:0]  last_waddr = '0;
    logic [31:0] last_wdata = '0;

    int          checks = 0, errors = 0;
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          wc;

    always #5 clk = ~clk;

    pio_reg_master #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .bus_write_addr(waddr), .bus_write_en(wen), .bus_wdata(wdata),
        .bus_read_addr(raddr), .bus_rdata(rdata)
    );

    pio_reg_master #(.ADDR_W(10), .DATA_W(32), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_op(3'd1),
        .req_addr(10'h0C8), .req_data(32'h0),
        .rsp_valid(rsp_valid3), .rsp_ready(1'b1), .rsp_data(rsp_data3), .rsp_err(rsp_err3),
        .bus_write_addr(waddr3), .bus_write_en(wen3), .bus_wdata(wdata3),
        .bus_read_addr(raddr3), .bus_rdata(rdata3)
    );

    // Register file model: RD_LAT=1 port reads combinationally, RD_LAT=3 port
    // goes through two pipeline stages so early sampling returns stale data.
    assign rdata  = mem[raddr[9:2]];
    assign rdata3 = rd3_p2;

    always @(posedge clk) begin
        rd3_p1 <= mem[raddr3[9:2]];
        rd3_p2 <= rd3_p1;
        if (wen) begin
            mem[waddr[9:2]] <= wdata;
            wr_cnt          <= wr_cnt + 1;
            last_waddr      <= waddr;
            last_wdata      <= wdata;
        end
        if (wen3) wr_cnt3 <= wr_cnt3 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge with dut1 idle; returns accept-to-rsp_valid latency.
    task automatic txn(input logic [2:0] op, input logic [9:0] addr, input logic [31:0] data,
                       output int l, output logic [31:0] d, output logic e);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        l = 1;
        while (!rsp_valid && l < 20) begin
            @(posedge clk); #1;
            l++;
        end
        d = rsp_data;
        e = rsp_err;
        @(posedge clk); #1;
        check("single_resp_cycle", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",  {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid",  {31'd0, rsp_valid}, 32'd0);
        check("rst_wen",        {31'd0, wen}, 32'd0);
        check("rst_waddr",      {22'd0, waddr}, 32'd0);
        check("rst_wdata",      wdata, 32'd0);
        check("rst_raddr",      {22'd0, raddr}, 32'd0);
        check("rst_rsp_data",   rsp_data, 32'd0);
        check("rst_rsp_err",    {31'd0, rsp_err}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // WRITE
        txn(3'd0, 10'h038, 32'hDEADBEEF, lat, rd, er);
        check("wr_lat",   lat, 32'd2);
        check("wr_data",  rd, 32'd0);
        check("wr_err",   {31'd0, er}, 32'd0);
        check("wr_count", wr_cnt, 32'd1);
        check("wr_addr",  {22'd0, last_waddr}, 32'h038);
        check("wr_wdata", last_wdata, 32'hDEADBEEF);

        // READ, RD_LAT=1
        txn(3'd0, 10'h0C8, 32'h00010000, lat, rd, er);
        wc = wr_cnt;
        txn(3'd1, 10'h0C8, 32'h0, lat, rd, er);
        check("rd1_lat",    lat, 32'd2);
        check("rd1_data",   rd, 32'h00010000);
        check("rd1_err",    {31'd0, er}, 32'd0);
        check("rd1_no_wr",  wr_cnt, wc);

        // READ, RD_LAT=3
        req_valid3 = 1'b1;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        lat = 1;
        while (!rsp_valid3 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rd3_lat",   lat, 32'd4);
        check("rd3_data",  rsp_data3, 32'h00010000);
        check("rd3_no_wr", wr_cnt3, 32'd0);
        @(posedge clk); #1;

        // SET / CLR / XOR chain on 0x000
        txn(3'd0, 10'h000, 32'h00000001, lat, rd, er);
        wc = wr_cnt;
        txn(3'd2, 10'h000, 32'h0000000F, lat, rd, er);
        check("set_lat",   lat, 32'd3);
        check("set_old",   rd, 32'h00000001);
        check("set_wdata", last_wdata, 32'h0000000F);
        check("set_addr",  {22'd0, last_waddr}, 32'h000);
        check("set_count", wr_cnt, wc + 1);
        txn(3'd3, 10'h000, 32'h00000003, lat, rd, er);
        check("clr_old",   rd, 32'h0000000F);
        check("clr_wdata", last_wdata, 32'h0000000C);
        txn(3'd4, 10'h000, 32'h000000FF, lat, rd, er);
        check("xor_old",   rd, 32'h0000000C);
        check("xor_wdata", last_wdata, 32'h000000F3);
        check("xor_count", wr_cnt, wc + 3);

        // Errors: misaligned address, illegal op
        wc = wr_cnt;
        txn(3'd1, 10'h0C9, 32'h0, lat, rd, er);
        check("mis_lat",  lat, 32'd1);
        check("mis_err",  {31'd0, er}, 32'd1);
        check("mis_data", rd, 32'd0);
        txn(3'd7, 10'h010, 32'h12345678, lat, rd, er);
        check("ill_lat",  lat, 32'd1);
        check("ill_err",  {31'd0, er}, 32'd1);
        check("ill_data", rd, 32'd0);
        check("err_no_wr", wr_cnt, wc);

        // Response backpressure with req_valid held high
        req_valid = 1'b1; req_op = 3'd1; req_addr = 10'h038; req_data = '0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_addr = 10'h0C8;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_lat", lat, 32'd2);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",     {31'd0, rsp_valid}, 32'd1);
            check("bp_data",      rsp_data, 32'hDEADBEEF);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_hs_valid", {31'd0, rsp_valid}, 32'd0);
        check("bp_hs_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        check("bp_second_accepted", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_second_data", rsp_data, 32'h00010000);
        @(posedge clk); #1;

        // Reset in the RD cycle of a SET
        wc = wr_cnt;
        req_valid = 1'b1; req_op = 3'd2; req_addr = 10'h038; req_data = 32'h00000001;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("mrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mrst_wen",       {31'd0, wen}, 32'd0);
        check("mrst_raddr",     {22'd0, raddr}, 32'd0);
        check("mrst_waddr",     {22'd0, waddr}, 32'd0);
        check("mrst_wdata",     wdata, 32'd0);
        check("mrst_rsp_data",  rsp_data, 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mrst_no_wr",   wr_cnt, wc);
        check("mrst_mem",     mem[10'h038 >> 2], 32'hDEADBEEF);
        check("mrst_idle",    {31'd0, req_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
